// File: rtl/bcd_char_formatter_pkg.sv
// Shared types and constants for the BCD character formatter.
package bcd_char_formatter_pkg;

    localparam int NUM_DIGITS = 10;
    localparam int BIN_W      = 32;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int CNT_W      = 6;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONVERT  = 3'd1,
        EMIT     = 3'd2,
        KICK     = 3'd3,
        WAIT_UPD = 3'd4
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/bcd_char_formatter_if.sv
// Request/character-stream bundle between a requester, the formatter and the LCD writer.
interface bcd_char_formatter_if;
    import bcd_char_formatter_pkg::*;

    logic             start;
    logic [BIN_W-1:0] value;
    logic             update_i;
    logic             valid_o;
    logic [7:0]       char_o;
    logic             start_update_o;
    logic             busy;

    modport master (
        output start, value, update_i,
        input  valid_o, char_o, start_update_o, busy
    );

    modport slave (
        input  start, value, update_i,
        output valid_o, char_o, start_update_o, busy
    );

endinterface

// File: rtl/bcd_char_formatter_dd_adjust.sv
// Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
module dd_adjust
    import bcd_char_formatter_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    output logic [BCD_W-1:0] bcd_out
);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign bcd_out[4*g +: 4] = (bcd_in[4*g +: 4] >= 4'd5) ? bcd_in[4*g +: 4] + 4'd3
                                                              : bcd_in[4*g +: 4];
    end

endmodule

// File: rtl/bcd_char_formatter.sv
// Converts a 32-bit value to a 10-character ASCII row (double-dabble), streams it
// MSD first, then kicks the downstream LCD writer and waits for its update to finish.
module bcd_char_formatter
    import bcd_char_formatter_pkg::*;
#(
    parameter bit LEADING_BLANK = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    bcd_char_formatter_if.slave  bus
);

    state_t                   state, state_nxt;
    logic [BIN_W-1:0]         bin_q;
    logic [BCD_W-1:0]         bcd_q, bcd_adj;
    logic [BCD_W+BIN_W-1:0]   dd_shift;
    logic [CNT_W-1:0]         cnt_q;
    logic                     lead_q, seen_q;
    logic                     valid_q, kick_q;
    logic [7:0]               char_q;

    logic                     valid_d, kick_d, busy_d;
    logic [7:0]               char_d;
    logic [3:0]               digit;
    logic                     last_step, last_col;

    dd_adjust u_dd_adjust (
        .bcd_in  (bcd_q),
        .bcd_out (bcd_adj)
    );

    assign dd_shift  = {bcd_adj, bin_q} << 1;
    // During EMIT the BCD register shifts left a nibble per column, so the MSD is always on top.
    assign digit     = bcd_q[BCD_W-1 -: 4];
    assign last_step = (cnt_q == CNT_W'(BIN_W - 1));
    assign last_col  = (cnt_q == CNT_W'(NUM_DIGITS - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.start) state_nxt = CONVERT;
            CONVERT:  if (last_step) state_nxt = EMIT;
            EMIT:     if (last_col)  state_nxt = KICK;
            KICK:     state_nxt = WAIT_UPD;
            WAIT_UPD: if (seen_q && !bus.update_i) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state != IDLE);
        valid_d = (state == EMIT);
        kick_d  = (state == KICK);
        char_d  = 8'h00;
        if (state == EMIT) begin
            if (LEADING_BLANK && lead_q && digit == 4'd0 && !last_col) char_d = ASCII_SPACE;
            else                                                      char_d = digit_char(digit);
        end
    end

    // Outputs are registered, so the character stream trails the EMIT state by one cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            lead_q  <= 1'b0;
            seen_q  <= 1'b0;
            valid_q <= 1'b0;
            kick_q  <= 1'b0;
            char_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            kick_q  <= kick_d;
            char_q  <= char_d;
            case (state)
                IDLE: if (bus.start) begin
                    bin_q  <= bus.value;
                    bcd_q  <= '0;
                    cnt_q  <= '0;
                    lead_q <= 1'b1;
                    seen_q <= 1'b0;
                end
                CONVERT: begin
                    {bcd_q, bin_q} <= dd_shift;
                    cnt_q          <= last_step ? '0 : cnt_q + 1'b1;
                end
                EMIT: begin
                    bcd_q <= {bcd_q[BCD_W-5:0], 4'h0};
                    cnt_q <= cnt_q + 1'b1;
                    if (digit != 4'd0) lead_q <= 1'b0;
                end
                WAIT_UPD: if (bus.update_i) seen_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.valid_o        = valid_q;
    assign bus.char_o         = char_q;
    assign bus.start_update_o = kick_q;
    assign bus.busy           = busy_d;

endmodule
